// File: rtl/req_pkg.sv
// Shared sizing constants and FSM state encoding for the request-capture block.
package req_pkg;
    localparam int NUM_REQ = 8;
    localparam int CODE_W  = 3;
    localparam int DROP_W  = 8;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;
endpackage

// File: rtl/encoder8_3.sv
// Eight-to-three one-hot encoder; an all-zero or multi-hot input yields code 0.
module encoder8_3
    import req_pkg::*;
(
    input  logic [NUM_REQ-1:0] onehot,
    output logic [CODE_W-1:0]  code
);

    // Map each legal one-hot pattern to its bit index.
    always_comb begin
        code = 3'd0;
        case (onehot)
            8'b0000_0001: code = 3'd0;
            8'b0000_0010: code = 3'd1;
            8'b0000_0100: code = 3'd2;
            8'b0000_1000: code = 3'd3;
            8'b0001_0000: code = 3'd4;
            8'b0010_0000: code = 3'd5;
            8'b0100_0000: code = 3'd6;
            8'b1000_0000: code = 3'd7;
            default:      code = 3'd0;
        endcase
    end

endmodule

// File: rtl/req_capture_onehot.sv
// Captures rising edges on level request lines into a pending set and presents
// them one at a time, highest index first, over a valid/ready one-hot output.
module req_capture_onehot #(
    parameter int NUM_REQ = req_pkg::NUM_REQ,
    parameter int CODE_W  = req_pkg::CODE_W,
    parameter int DROP_W  = req_pkg::DROP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [NUM_REQ-1:0] out_onehot,
    output logic [CODE_W-1:0]  out_code,
    output logic [NUM_REQ-1:0] pending_o,
    output logic [DROP_W-1:0]  drop_cnt
);

    function automatic logic [NUM_REQ-1:0] pick_highest(input logic [NUM_REQ-1:0] vec);
        logic [NUM_REQ-1:0] sel;
        sel = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vec[i]) begin
                sel    = {NUM_REQ{1'b0}};
                sel[i] = 1'b1;
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    function automatic logic [CODE_W:0] count_ones(input logic [NUM_REQ-1:0] vec);
        logic [CODE_W:0] cnt;
        cnt = {(CODE_W+1){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt = cnt + {{CODE_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    req_pkg::state_e state_r, state_nxt_s;

    logic [NUM_REQ-1:0]       req_prev_r;
    logic [NUM_REQ-1:0]       pending_r;
    logic [NUM_REQ-1:0]       pending_nxt_s;
    logic [NUM_REQ-1:0]       edge_s;
    logic [NUM_REQ-1:0]       winner_s;
    logic [CODE_W-1:0]        winner_code_s;
    logic [NUM_REQ-1:0]       load_mask_s;
    logic [NUM_REQ-1:0]       drop_vec_s;
    logic [CODE_W:0]          drop_num_s;
    logic [DROP_W+CODE_W:0]   drop_sum_s;
    logic [DROP_W-1:0]        drop_cnt_r;
    logic [DROP_W-1:0]        drop_nxt_s;
    logic                     load_s;
    logic                     clear_s;
    logic                     out_valid_r;
    logic [NUM_REQ-1:0]       out_onehot_r;
    logic [CODE_W-1:0]        out_code_r;

    assign edge_s   = req_in & ~req_prev_r;
    assign winner_s = pick_highest(pending_r);

    encoder8_3 u_enc (
        .onehot (winner_s),
        .code   (winner_code_s)
    );

    // Handshake FSM: decides when a new winner is loaded or the output is cleared.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            req_pkg::ST_IDLE: begin
                if (|pending_r) begin
                    load_s      = 1'b1;
                    state_nxt_s = req_pkg::ST_PRESENT;
                end else begin
                    state_nxt_s = req_pkg::ST_IDLE;
                end
            end
            req_pkg::ST_PRESENT: begin
                if (out_ready) begin
                    if (|pending_r) begin
                        load_s = 1'b1;
                    end else begin
                        clear_s     = 1'b1;
                        state_nxt_s = req_pkg::ST_IDLE;
                    end
                end else begin
                    state_nxt_s = req_pkg::ST_PRESENT;
                end
            end
            default: begin
                clear_s     = 1'b1;
                state_nxt_s = req_pkg::ST_IDLE;
            end
        endcase
    end

    // Pending update and drop accounting; a new edge beats a same-cycle load.
    always_comb begin
        load_mask_s = {NUM_REQ{1'b0}};
        if (load_s) begin
            load_mask_s = winner_s;
        end else begin
            load_mask_s = {NUM_REQ{1'b0}};
        end
        drop_vec_s    = edge_s & pending_r & ~load_mask_s;
        pending_nxt_s = (pending_r & ~load_mask_s) | edge_s;
        drop_num_s    = count_ones(drop_vec_s);
        drop_sum_s    = {{(CODE_W+1){1'b0}}, drop_cnt_r} + {{DROP_W{1'b0}}, drop_num_s};
        drop_nxt_s    = drop_cnt_r;
        if (drop_sum_s > {{(CODE_W+1){1'b0}}, {DROP_W{1'b1}}}) begin
            drop_nxt_s = {DROP_W{1'b1}};
        end else begin
            drop_nxt_s = drop_sum_s[DROP_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= req_pkg::ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Edge-detect history, pending set and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_prev_r <= {NUM_REQ{1'b0}};
            pending_r  <= {NUM_REQ{1'b0}};
            drop_cnt_r <= {DROP_W{1'b0}};
        end else begin
            req_prev_r <= req_in;
            pending_r  <= pending_nxt_s;
            drop_cnt_r <= drop_nxt_s;
        end
    end

    // Output register: load a winner, clear on return to idle, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_onehot_r <= {NUM_REQ{1'b0}};
            out_code_r   <= {CODE_W{1'b0}};
        end else begin
            out_valid_r <= (state_nxt_s == req_pkg::ST_PRESENT);
            if (load_s) begin
                out_onehot_r <= winner_s;
                out_code_r   <= winner_code_s;
            end else if (clear_s) begin
                out_onehot_r <= {NUM_REQ{1'b0}};
                out_code_r   <= {CODE_W{1'b0}};
            end else begin
                out_onehot_r <= out_onehot_r;
                out_code_r   <= out_code_r;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_onehot = out_onehot_r;
    assign out_code   = out_code_r;
    assign pending_o  = pending_r;
    assign drop_cnt   = drop_cnt_r;

endmodule
